// File: rtl/gerador_soma_pontos_pkg.sv
// Shared types and constants for the team score write front end.
// Defaults are shared with the points register instance.
package gerador_soma_pontos_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        PULSE = 2'd2,
        WAIT  = 2'd3
    } estado_t;

    localparam logic [1:0] PTS_1   = 2'd1;
    localparam logic [1:0] PTS_2   = 2'd2;
    localparam logic [1:0] PTS_3   = 2'd3;
    localparam logic [1:0] PTS_SUB = 2'd1;

    localparam int WIDTH_PADRAO        = 7;
    localparam int MAX_SCORE_PADRAO    = 99;
    localparam int VALIDATE_LAT_PADRAO = 3;

endpackage

// File: rtl/gerador_soma_pontos_if.sv
// Button, feedback and write-port bundle between the score
// generator and its surroundings.
interface gerador_soma_pontos_if
    import gerador_soma_pontos_pkg::*;
#(
    parameter int WIDTH = WIDTH_PADRAO
);
    logic             btn_1pt;
    logic             btn_2pt;
    logic             btn_3pt;
    logic             btn_sub1;
    logic [WIDTH-1:0] pontos_atual;
    logic [WIDTH-1:0] soma;
    logic             validar_soma;
    logic             ocupado;
    logic             saturado;

    modport master (
        output btn_1pt, btn_2pt, btn_3pt, btn_sub1,
        output pontos_atual,
        input  soma, validar_soma, ocupado, saturado
    );

    modport slave (
        input  btn_1pt, btn_2pt, btn_3pt, btn_sub1,
        input  pontos_atual,
        output soma, validar_soma, ocupado, saturado
    );

endinterface

// File: rtl/gerador_soma_pontos_sincronizador_borda.sv
// Two-flop synchronizer plus rising-edge detector for one button.
// One single-cycle pulse per press, however long it is held.
module sincronizador_borda (
    input  logic clock,
    input  logic clr,
    input  logic entrada,
    output logic pulso
);
    logic s1, s2, s3;

    // Synchronize the level, keep one extra stage for edge detection
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= entrada;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulso = s2 & ~s3;

endmodule

// File: rtl/gerador_soma_pontos.sv
// Score write front end: button events to a clamped score
// and a one-cycle write strobe, holding soma until it lands.
module gerador_soma_pontos
    import gerador_soma_pontos_pkg::*;
#(
    parameter int WIDTH        = WIDTH_PADRAO,
    parameter int MAX_SCORE    = MAX_SCORE_PADRAO,
    parameter int VALIDATE_LAT = VALIDATE_LAT_PADRAO
) (
    input  logic                  clock,
    input  logic                  clr,
    gerador_soma_pontos_if.slave  bus
);
    localparam int CW = $clog2(VALIDATE_LAT + 1) + 1;

    estado_t          estado, proximo;
    logic [3:0]       ev;
    logic             unico;
    logic [1:0]       delta_d, delta_q;
    logic             sub_d, sub_q;
    logic [WIDTH:0]   ext, limite, calc;
    logic             sem_efeito;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] soma_q;
    logic             sat_q;

    sincronizador_borda u_b1 (
        .clock(clock), .clr(clr),
        .entrada(bus.btn_1pt), .pulso(ev[0])
    );
    sincronizador_borda u_b2 (
        .clock(clock), .clr(clr),
        .entrada(bus.btn_2pt), .pulso(ev[1])
    );
    sincronizador_borda u_b3 (
        .clock(clock), .clr(clr),
        .entrada(bus.btn_3pt), .pulso(ev[2])
    );
    sincronizador_borda u_bs (
        .clock(clock), .clr(clr),
        .entrada(bus.btn_sub1), .pulso(ev[3])
    );

    assign unico = (ev != 4'd0) && ((ev & (ev - 4'd1)) == 4'd0);

    // Decode a lone event into its delta; collisions decode to nothing
    always_comb begin
        delta_d = 2'd0;
        sub_d   = 1'b0;
        if (unico) begin
            unique case (1'b1)
                ev[0]: delta_d = PTS_1;
                ev[1]: delta_d = PTS_2;
                ev[2]: delta_d = PTS_3;
                ev[3]: begin
                    delta_d = PTS_SUB;
                    sub_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // One bit of headroom so the clamp sees the true sum
    always_comb begin
        ext    = {1'b0, bus.pontos_atual} + (WIDTH+1)'(delta_q);
        limite = (WIDTH+1)'(MAX_SCORE);
        if (sub_q) begin
            if (bus.pontos_atual == '0)
                calc = '0;
            else
                calc = {1'b0, bus.pontos_atual} - (WIDTH+1)'(delta_q);
        end else begin
            calc = (ext > limite) ? limite : ext;
        end
        sem_efeito = (calc == {1'b0, bus.pontos_atual});
    end

    // State register
    always_ff @(posedge clock or posedge clr) begin
        if (clr)
            estado <= IDLE;
        else
            estado <= proximo;
    end

    // Next-state logic; events outside IDLE are simply not looked at
    always_comb begin
        proximo = estado;
        unique case (estado)
            IDLE:  if (unico) proximo = CALC;
            CALC:  proximo = sem_efeito ? IDLE : PULSE;
            PULSE: proximo = WAIT;
            WAIT:  if (cnt == CW'(VALIDATE_LAT)) proximo = IDLE;
            default: proximo = IDLE;
        endcase
    end

    // Datapath: capture delta, update soma only in CALC, time the wait
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            delta_q <= 2'd0;
            sub_q   <= 1'b0;
            soma_q  <= '0;
            sat_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            sat_q <= (estado == CALC) && sem_efeito;
            if (estado == IDLE && unico) begin
                delta_q <= delta_d;
                sub_q   <= sub_d;
            end
            if (estado == CALC && !sem_efeito)
                soma_q <= calc[WIDTH-1:0];
            if (estado == PULSE)
                cnt <= '0;
            else if (estado == WAIT)
                cnt <= cnt + CW'(1);
        end
    end

    // Moore outputs
    always_comb begin
        bus.validar_soma = (estado == PULSE);
        bus.ocupado      = (estado != IDLE);
        bus.soma         = soma_q;
        bus.saturado     = sat_q;
    end

endmodule
